mc_pi_sample_ctrl: RTL and testbench

//  Sequences one shared LFSR (lfsr18-style, XNOR feedback) to run a Monte-Carlo pi estimate.
//  Per sample: draws an x and a y coordinate from two consecutive LFSR states and tests
//   x^2+y^2 < 2^(2*COORD_W) (quarter circle).

---
 rtl/mc_pi_sample_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mc_pi_sample_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_pi_sample_ctrl.sv
// Monte-Carlo pi sample controller. Drives an external XNOR LFSR (load, seed, step enable),
// draws x and y from two consecutive LFSR states, tests the point against the quarter circle,
// accumulates hit/total counts and hands each point to a plotter over a valid/ready link.
module mc_pi_sample_ctrl #(
  parameter int unsigned RAND_W  = 18,
  parameter int unsigned COORD_W = 9,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic [RAND_W-1:0]  seed_in,
  input  logic [RAND_W-1:0]  lfsr_q,
  output logic               lfsr_load,
  output logic [RAND_W-1:0]  lfsr_seed,
  output logic               lfsr_en,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   hits,
  output logic [CNT_W-1:0]   total,
  output logic               pt_valid,
  input  logic               pt_ready,
  output logic [COORD_W-1:0] pt_x,
  output logic [COORD_W-1:0] pt_y,
  output logic               pt_inside
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSeed  = 3'd1;
  localparam logic [2:0] StDrawX = 3'd2;
  localparam logic [2:0] StDrawY = 3'd3;
  localparam logic [2:0] StCheck = 3'd4;
  localparam logic [2:0] StEmit  = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  localparam int unsigned SqW = 2 * COORD_W + 1;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [RAND_W-1:0]  seed_q, seed_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               inside_q, inside_d;
  logic [CNT_W-1:0]   hits_q, hits_d, total_q, total_d;
  logic               done_q, done_d;
  logic [SqW-1:0]     sq;
  logic               inside_now;
  logic               unused_lfsr_bits;

  // Only the low COORD_W bits of the LFSR state feed the coordinates.
  assign unused_lfsr_bits = ^lfsr_q;

  // Squared radius at full width; inside when the top bit (2^(2*COORD_W)) is clear.
  assign sq         = SqW'(x_q) * SqW'(x_q) + SqW'(y_q) * SqW'(y_q);
  assign inside_now = ~sq[SqW-1];

  // Next-state logic; abort outside IDLE overrides everything and freezes partial results.
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    seed_d   = seed_q;
    x_d      = x_q;
    y_d      = y_q;
    inside_d = inside_q;
    hits_d   = hits_q;
    total_d  = total_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          hits_d  = '0;
          total_d = '0;
          if (num_samples != '0) begin
            num_d   = num_samples;
            seed_d  = seed_in;
            state_d = StSeed;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StSeed:  state_d = StDrawX;
      StDrawX: begin
        x_d     = lfsr_q[COORD_W-1:0];
        state_d = StDrawY;
      end
      StDrawY: begin
        y_d     = lfsr_q[COORD_W-1:0];
        state_d = StCheck;
      end
      StCheck: begin
        inside_d = inside_now;
        total_d  = total_q + 1'b1;
        hits_d   = hits_q + CNT_W'(inside_now);
        state_d  = StEmit;
      end
      StEmit: begin
        if (pt_ready) begin
          if (total_q == num_q) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StDrawX;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) begin
      state_d  = StIdle;
      x_d      = x_q;
      y_d      = y_q;
      inside_d = inside_q;
      hits_d   = hits_q;
      total_d  = total_q;
      done_d   = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      num_q    <= '0;
      seed_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      inside_q <= 1'b0;
      hits_q   <= '0;
      total_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      seed_q   <= seed_d;
      x_q      <= x_d;
      y_q      <= y_d;
      inside_q <= inside_d;
      hits_q   <= hits_d;
      total_q  <= total_d;
      done_q   <= done_d;
    end
  end

  // Moore outputs; an all-ones seed would lock the XNOR LFSR, so it is replaced by zero.
  always_comb begin
    lfsr_load = (state_q == StSeed);
    lfsr_seed = (&seed_q) ? '0 : seed_q;
    lfsr_en   = (state_q == StDrawX) || (state_q == StDrawY);
    busy      = (state_q != StIdle);
    pt_valid  = (state_q == StEmit);
    done      = done_q;
    hits      = hits_q;
    total     = total_q;
    pt_x      = x_q;
    pt_y      = y_q;
    pt_inside = inside_q;
  end

endmodule

// File: tb/tb_mc_pi_sample_ctrl.sv
// Bench for mc_pi_sample_ctrl: models the external LFSR, computes expected points and counts
// from the sampling rules, and checks a table of runs plus reset/abort/stall corner cases.
module tb_mc_pi_sample_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort, pt_ready;
  logic [31:0] num_samples;
  logic [17:0] seed_in, lfsr_q, lfsr_seed;
  logic        lfsr_load, lfsr_en, busy, done, pt_valid, pt_inside;
  logic [31:0] hits, total;
  logic [8:0]  pt_x, pt_y;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mc_pi_sample_ctrl #(.RAND_W(18), .COORD_W(9), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .num_samples(num_samples),
    .seed_in(seed_in), .lfsr_q(lfsr_q), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
    .lfsr_en(lfsr_en), .busy(busy), .done(done), .hits(hits), .total(total),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y), .pt_inside(pt_inside)
  );

  function automatic logic [17:0] lfsr_step(input logic [17:0] s);
    return {s[16:0], ~(s[17] ^ s[10])};
  endfunction

  // External LFSR instance model.
  always @(posedge clk) begin
    if (reset)          lfsr_q <= '0;
    else if (lfsr_load) lfsr_q <= lfsr_seed;
    else if (lfsr_en)   lfsr_q <= lfsr_step(lfsr_q);
  end

  function automatic bit in_circle(input int x, input int y);
    return (x * x + y * y) < (1 << 18);
  endfunction

  function automatic int model_hits(input logic [17:0] seed, input int n);
    logic [17:0] s;
    int h, x, y;
    s = (&seed) ? 18'h0 : seed;
    h = 0;
    for (int i = 0; i < n; i++) begin
      x = int'(s[8:0]); s = lfsr_step(s);
      y = int'(s[8:0]); s = lfsr_step(s);
      if (in_circle(x, y)) h++;
    end
    return h;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [17:0] seed;
    int          num;
    int          stall;
    bit          rnd;
    int          abort_at;
    int          exp_hits;
    int          exp_total;
  } vec_t;

  task automatic do_run(input vec_t v);
    logic [17:0] ms;
    int  mh, idx, cyc, stall_cnt, ex, ey, bound;
    bit  have_exp, finished, rdy, ab, exp_in;
    ms = (&v.seed) ? 18'h0 : v.seed;
    mh = 0; idx = 0; cyc = 1; stall_cnt = 0; have_exp = 0; finished = 0;
    ex = 0; ey = 0; exp_in = 0;
    bound = 20 * v.num + 50;
    @(negedge clk);
    start = 1'b1; num_samples = v.num; seed_in = v.seed; pt_ready = 1'b0; abort = 1'b0;
    @(negedge clk);
    start = 1'b0; num_samples = $urandom; seed_in = 18'($urandom);
    if (v.num == 0) begin
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_hits", hits, 0);
      check("zero_total", total, 0);
      check("zero_en", lfsr_en, 0);
      @(negedge clk);
      check("zero_done_drop", done, 0);
      check("zero_en2", lfsr_en, 0);
      return;
    end
    check("seed_busy", busy, 1);
    check("seed_load", lfsr_load, 1);
    check("seed_value", lfsr_seed, ms);
    check("start_clr_hits", hits, 0);
    check("start_clr_total", total, 0);
    while (!finished && cyc < bound) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; abort = 1'b0;
      if (!pt_valid) begin
        pt_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        continue;
      end
      if (idx == 0 && !have_exp) check("latency", cyc, 5);
      if (!have_exp) begin
        ex = int'(ms[8:0]); ms = lfsr_step(ms);
        ey = int'(ms[8:0]); ms = lfsr_step(ms);
        exp_in = in_circle(ex, ey);
        have_exp = 1;
      end
      check("pt_x", pt_x, ex);
      check("pt_y", pt_y, ey);
      check("pt_inside", pt_inside, exp_in);
      check("total_frozen", total, idx + 1);
      check("en_in_emit", lfsr_en, 0);
      if (v.stall > 0 && idx == 0 && stall_cnt < v.stall) begin
        rdy = 1'b0; stall_cnt++;
      end else begin
        rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      ab = (idx + 1 == v.abort_at);
      if (ab) rdy = 1'b1;
      if (v.rnd && ($urandom_range(0, 3) == 0)) begin
        start = 1'b1; num_samples = $urandom_range(1, 5);
      end
      pt_ready = rdy; abort = ab;
      if (rdy) begin
        if (exp_in) mh++;
        idx++;
        have_exp = 0;
        if (ab) begin
          @(negedge clk);
          abort = 1'b0; start = 1'b0; pt_ready = 1'b0;
          check("abort_busy", busy, 0);
          check("abort_valid", pt_valid, 0);
          check("abort_en", lfsr_en, 0);
          check("abort_total", total, v.exp_total);
          check("abort_hits", hits, v.exp_hits);
          for (int k = 0; k < 3; k++) begin
            check("abort_no_done", done, 0);
            @(negedge clk);
          end
          finished = 1;
        end else if (idx == v.num) begin
          @(negedge clk);
          start = 1'b0; pt_ready = 1'b0;
          check("done_pulse", done, 1);
          check("done_busy", busy, 1);
          check("hits_model", hits, mh);
          check("hits_table", hits, v.exp_hits);
          check("total_table", total, v.exp_total);
          @(negedge clk);
          check("done_drop", done, 0);
          check("idle_busy", busy, 0);
          finished = 1;
        end
      end
    end
    if (!finished) check("run_timeout", 0, 1);
    start = 1'b0; abort = 1'b0; pt_ready = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{18'h0AACC, 1, 0, 0, -1, 1, 1};
    vecs[1] = '{18'h12345, 0, 0, 0, -1, 0, 0};
    vecs[2] = '{18'h00001, 4, 10, 0, -1, model_hits(18'h00001, 4), 4};
    vecs[3] = '{18'h3FFFF, 5, 0, 0, -1, model_hits(18'h3FFFF, 5), 5};
    vecs[4].seed = 18'($urandom); vecs[4].num = 20; vecs[4].stall = 0; vecs[4].rnd = 1;
    vecs[4].abort_at = -1; vecs[4].exp_hits = model_hits(vecs[4].seed, 20);
    vecs[4].exp_total = 20;
    vecs[5].seed = 18'($urandom); vecs[5].num = 100; vecs[5].stall = 0; vecs[5].rnd = 0;
    vecs[5].abort_at = 37; vecs[5].exp_hits = model_hits(vecs[5].seed, 37);
    vecs[5].exp_total = 37;
    vecs[6].seed = 18'($urandom); vecs[6].num = 6; vecs[6].stall = 0; vecs[6].rnd = 1;
    vecs[6].abort_at = -1; vecs[6].exp_hits = model_hits(vecs[6].seed, 6);
    vecs[6].exp_total = 6;

    reset = 1'b1; start = 1'b0; abort = 1'b0; pt_ready = 1'b0;
    num_samples = '0; seed_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hits", hits, 0);
    check("rst_total", total, 0);
    check("rst_valid", pt_valid, 0);
    check("rst_en", lfsr_en, 0);
    check("rst_load", lfsr_load, 0);

    for (int i = 0; i < 7; i++) begin
      do_run(vecs[i]);
      if (i == 0) begin
        check("t1_x", pt_x, 204);
        check("t1_y", pt_y, 409);
        check("t1_inside", pt_inside, 1);
        check("t1_hits_hold", hits, 1);
        check("t1_total_hold", total, 1);
      end
    end

    // Reset in the middle of a long run.
    @(negedge clk);
    start = 1'b1; num_samples = 1000; seed_in = 18'($urandom); pt_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pt_ready = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_hits", hits, 0);
    check("mid_rst_total", total, 0);
    check("mid_rst_valid", pt_valid, 0);
    check("mid_rst_x", pt_x, 0);
    check("mid_rst_y", pt_y, 0);
    check("mid_rst_inside", pt_inside, 0);
    check("mid_rst_load", lfsr_load, 0);
    check("mid_rst_seed", lfsr_seed, 0);
    check("mid_rst_en", lfsr_en, 0);
    reset = 1'b0;
    do_run(vecs[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
